// File: rtl/cmac_sched.sv
// cmac_sched: complex MAC scheduler driving a four-product unit; define CMAC_SAT_EN for saturating accumulation.
module cmac_sched #(
  parameter int LEN     = 32,
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_re,
  input  logic [31:0] a_im,
  input  logic [31:0] b_re,
  input  logic [31:0] b_im,
  output logic [31:0] mul_a1,
  output logic [31:0] mul_a2,
  output logic [31:0] mul_b1,
  output logic [31:0] mul_b2,
  input  logic [31:0] mul_p11,
  input  logic [31:0] mul_p22,
  input  logic [31:0] mul_p12,
  input  logic [31:0] mul_p21,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_re,
  output logic [31:0] res_im,
  output logic        busy,
  output logic        ovf
);
  localparam int CW = $clog2(LEN + 1);
`ifdef CMAC_SAT_EN
  localparam int SW = 34;
`else
  localparam int SW = 32;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] iss_q, iss_d, acc_cnt_q, acc_cnt_d;
  logic [MUL_LAT:0] tag_q;
  logic [31:0] acc_re_q, acc_im_q, acc_re_d, acc_im_d;
  logic [31:0] res_re_q, res_im_q, new_re, new_im;
  logic [31:0] mul_a1_q, mul_a2_q, mul_b1_q, mul_b2_q;
  logic in_ready_q, res_valid_q, busy_q, ovf_q, ovf_d;
  logic issue, acc_en, go, clip_re, clip_im;
  logic signed [SW-1:0] sum_re, sum_im;
  always_comb begin
    issue = in_ready_q & in_valid;
    acc_en = tag_q[MUL_LAT];
    go = (state_q == IDLE) & start;
    sum_re = SW'(signed'(acc_re_q)) + SW'(signed'(mul_p11)) - SW'(signed'(mul_p22));
    sum_im = SW'(signed'(acc_im_q)) + SW'(signed'(mul_p12)) + SW'(signed'(mul_p21));
`ifdef CMAC_SAT_EN
    clip_re = sum_re[33:31] != {3{sum_re[33]}};
    clip_im = sum_im[33:31] != {3{sum_im[33]}};
    new_re = clip_re ? (sum_re[33] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum_re[31:0];
    new_im = clip_im ? (sum_im[33] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum_im[31:0];
`else
    clip_re = 1'b0;
    clip_im = 1'b0;
    new_re = sum_re;
    new_im = sum_im;
`endif
    iss_d = go ? '0 : iss_q + CW'(issue);
    acc_cnt_d = go ? '0 : acc_cnt_q + CW'(acc_en);
    acc_re_d = go ? '0 : acc_en ? new_re : acc_re_q;
    acc_im_d = go ? '0 : acc_en ? new_im : acc_im_q;
    ovf_d = go ? 1'b0 : ovf_q | (acc_en & (clip_re | clip_im));
    state_d = state_q;
    if (go)
      state_d = RUN;
    else if ((state_q == RUN || state_q == DRAIN) && acc_cnt_d == CW'(LEN))
      state_d = DONE;
    else if (state_q == RUN && iss_d == CW'(LEN))
      state_d = DRAIN;
    else if (state_q == DONE && res_ready)
      state_d = IDLE;
  end
  // Tags ride MUL_LAT+1 stages so the accumulate lands one edge after products settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      iss_q       <= '0;
      acc_cnt_q   <= '0;
      tag_q       <= '0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      res_re_q    <= '0;
      res_im_q    <= '0;
      mul_a1_q    <= '0;
      mul_a2_q    <= '0;
      mul_b1_q    <= '0;
      mul_b2_q    <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      iss_q       <= iss_d;
      acc_cnt_q   <= acc_cnt_d;
      tag_q       <= {tag_q[MUL_LAT-1:0], issue};
      acc_re_q    <= acc_re_d;
      acc_im_q    <= acc_im_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d == RUN) && (iss_d != CW'(LEN));
      res_valid_q <= state_d == DONE;
      busy_q      <= state_d != IDLE;
      if (issue) begin
        mul_a1_q <= a_re;
        mul_a2_q <= a_im;
        mul_b1_q <= b_re;
        mul_b2_q <= b_im;
      end
      if (state_d == DONE && state_q != DONE) begin
        res_re_q <= acc_re_d;
        res_im_q <= acc_im_d;
      end
    end
  end
  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;
  assign res_re    = res_re_q;
  assign res_im    = res_im_q;
  assign mul_a1    = mul_a1_q;
  assign mul_a2    = mul_a2_q;
  assign mul_b1    = mul_b1_q;
  assign mul_b2    = mul_b2_q;
endmodule

// File: tb/tb_cmac_sched.sv
// tb_cmac_sched: table-driven and randomized checks of cmac_sched (LEN=4, MUL_LAT=1) with a behavioural product unit.
module tb_cmac_sched;
  localparam int LEN = 4;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, res_ready = 0;
  logic [31:0] a_re = 0, a_im = 0, b_re = 0, b_im = 0;
  logic in_ready, res_valid, busy, ovf;
  logic [31:0] mul_a1, mul_a2, mul_b1, mul_b2, res_re, res_im;
  logic [31:0] mul_p11 = 0, mul_p22 = 0, mul_p12 = 0, mul_p21 = 0;
  int tests = 0, fails = 0;
  logic [31:0] t_ar[LEN], t_ai[LEN], t_br[LEN], t_bi[LEN];

  cmac_sched #(.LEN(LEN), .MUL_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .mul_a1(mul_a1), .mul_a2(mul_a2), .mul_b1(mul_b1), .mul_b2(mul_b2),
    .mul_p11(mul_p11), .mul_p22(mul_p22), .mul_p12(mul_p12), .mul_p21(mul_p21),
    .res_valid(res_valid), .res_ready(res_ready), .res_re(res_re), .res_im(res_im),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Q5.27 x Q5.27 -> Q10.22
  function automatic longint prod(input logic [31:0] a, input logic [31:0] b);
    return (longint'($signed(a)) * longint'($signed(b))) >>> 32;
  endfunction

  always_ff @(posedge clk) begin
    mul_p11 <= 32'(prod(mul_a1, mul_b1));
    mul_p22 <= 32'(prod(mul_a2, mul_b2));
    mul_p12 <= 32'(prod(mul_a1, mul_b2));
    mul_p21 <= 32'(prod(mul_a2, mul_b1));
  end

  function automatic longint reduce(input longint v, inout bit o);
`ifdef CMAC_SAT_EN
    if (v > 64'sd2147483647) begin o = 1; return 64'sd2147483647; end
    if (v < -64'sd2147483648) begin o = 1; return -64'sd2147483648; end
    return v;
`else
    logic [63:0] u;
    u = v;
    return longint'($signed(u[31:0]));
`endif
  endfunction

  task automatic model(output logic [31:0] er, output logic [31:0] ei, output logic eo);
    longint ar = 0, ai = 0;
    bit o = 0;
    for (int k = 0; k < LEN; k++) begin
      ar = reduce(ar + prod(t_ar[k], t_br[k]) - prod(t_ai[k], t_bi[k]), o);
      ai = reduce(ai + prod(t_ar[k], t_bi[k]) + prod(t_ai[k], t_br[k]), o);
    end
    er = 32'(ar);
    ei = 32'(ai);
    eo = o;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input string name, input bit gap, input int hold, input bit pulse,
                     input logic [31:0] er, input logic [31:0] ei, input bit eo, input int elat);
    int k = 0, cyc = 0, idx;
    bit tog = 0, fire;
    logic [31:0] r_re, r_im;
    @(negedge clk); start = 1;
    @(posedge clk);
    @(negedge clk); start = 0;
    while (!res_valid && cyc < 100) begin
      idx = (k < LEN) ? k : LEN - 1;
      in_valid = gap ? ((k < LEN) && tog) : 1'b1;
      start = pulse && cyc == 2;
      tog = ~tog;
      a_re = t_ar[idx]; a_im = t_ai[idx]; b_re = t_br[idx]; b_im = t_bi[idx];
      fire = in_valid && in_ready;
      @(posedge clk);
      cyc++;
      if (fire) k++;
      @(negedge clk);
    end
    in_valid = 0;
    start = 0;
    chk({name, " res_valid"}, res_valid, 1);
    if (elat >= 0) chk({name, " latency"}, cyc, elat);
    chk({name, " re"}, res_re, er);
    chk({name, " im"}, res_im, ei);
    chk({name, " ovf"}, ovf, eo);
    chk({name, " in_ready in DONE"}, in_ready, 0);
    r_re = res_re;
    r_im = res_im;
    for (int h = 0; h < hold; h++) begin
      res_ready = 0;
      start = pulse && h == 0;
      @(posedge clk);
      @(negedge clk);
      start = 0;
      chk({name, " hold"}, {res_valid, busy, res_re, res_im}, {2'b11, r_re, r_im});
    end
    res_ready = 1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 0;
    chk({name, " after accept"}, {res_valid, busy, res_re, res_im}, {2'b00, r_re, r_im});
  endtask

  task automatic fill(input logic [31:0] ar, input logic [31:0] ai, input logic [31:0] br, input logic [31:0] bi);
    for (int k = 0; k < LEN; k++) begin
      t_ar[k] = ar; t_ai[k] = ai; t_br[k] = br; t_bi[k] = bi;
    end
  endtask

  typedef struct {
    string name;
    logic [31:0] ar, ai, br, bi;
    bit gap;
    int hold;
    bit pulse;
    logic [31:0] er, ei;
    bit eo;
    int elat;
  } vec_t;

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    v = $urandom();
    return 32'($signed(v) >>> $urandom_range(0, 6));
  endfunction

  initial begin
    vec_t v[5];
    logic [31:0] er, ei;
    logic eo;
    v[0] = '{"one_plus_j", 32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 0, 0, 0, 0, 32'h0100_0000, 32'h0100_0000, 0, 6};
    v[1] = '{"j_times_j", 0, 32'h0800_0000, 0, 32'h0800_0000, 0, 1, 0, 32'hFF00_0000, 0, 0, 6};
    v[2] = '{"gapped", 32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 0, 1, 5, 0, 32'h0100_0000, 32'h0100_0000, 0, -1};
`ifdef CMAC_SAT_EN
    v[3] = '{"overflow", 32'h7C00_0000, 0, 32'h7C00_0000, 0, 0, 2, 0, 32'h7FFF_FFFF, 0, 1, 6};
`else
    v[3] = '{"overflow", 32'h7C00_0000, 0, 32'h7C00_0000, 0, 0, 2, 0, 32'hF040_0000, 0, 0, 6};
`endif
    v[4] = '{"start_ignored", 32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 0, 0, 2, 1, 32'h0100_0000, 32'h0100_0000, 0, 6};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset state", {in_ready, res_valid, busy, ovf, res_re, res_im, mul_a1, mul_a2, mul_b1, mul_b2}, 0);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      fill(v[i].ar, v[i].ai, v[i].br, v[i].bi);
      run(v[i].name, v[i].gap, v[i].hold, v[i].pulse, v[i].er, v[i].ei, v[i].eo, v[i].elat);
    end
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < LEN; k++) begin
        t_ar[k] = rnd_op(); t_ai[k] = rnd_op(); t_br[k] = rnd_op(); t_bi[k] = rnd_op();
      end
      model(er, ei, eo);
      run("random", 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0, er, ei, eo, -1);
    end
    // reset in the middle of a dot product, then a clean run
    fill(32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 0);
    @(negedge clk); start = 1;
    @(posedge clk);
    @(negedge clk); start = 0; in_valid = 1;
    a_re = 32'h0800_0000; a_im = 32'h0800_0000; b_re = 32'h0800_0000; b_im = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); in_valid = 0; rst = 1;
    @(posedge clk);
    @(negedge clk); rst = 0;
    chk("mid-run reset", {in_ready, res_valid, busy, ovf, res_re, res_im, mul_a1, mul_a2, mul_b1, mul_b2}, 0);
    run("after reset", 0, 0, 0, 32'h0100_0000, 32'h0100_0000, 0, 6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
